// File: rtl/regslv_alias_bank.sv
// regslv_alias_bank: one shared register field reachable through ALIAS_NUM word addresses.
// Each alias can be read-write or read-only (RO_MASK), and a read of an alias can clear
// the field (RCLR_MASK). Requests use a simple strobe handshake with a single transaction
// outstanding. Hardware can load the field with hw_pulse, and sync_rst restores ARST_VALUE.
//
// Optional build macro REGSLV_ALIAS_BANK_RD_PIPE_EN adds an RDPIPE state before ACK.
// This registers rd_data/err one extra cycle, giving a latency of 3 instead of 2.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   req_vld          request strobe, sampled only in IDLE
//   wr_en, rd_en     command; exactly one must be set
//   addr, wr_data    request address and write data
//   ack_vld          one-cycle completion pulse, qualifies rd_data and err
//   rd_data          old field value at [F_LSB +: F_WIDTH] on good reads, else zero
//   err              decode or command error
//   sync_rst         synchronous field reset (highest priority)
//   hw_value         hardware load value, applied when hw_pulse is high
//   hw_pulse         hardware load strobe
//   field_value      registered field
//   swacc            one-hot pulse marking the alias touched by a good access
module regslv_alias_bank #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned F_WIDTH    = 8,
  parameter int unsigned F_LSB      = 0,
  parameter int unsigned ALIAS_NUM  = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ALIAS_NUM-1:0]  RO_MASK    = '0,
  parameter logic [ALIAS_NUM-1:0]  RCLR_MASK  = '0,
  parameter logic [F_WIDTH-1:0]    ARST_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_vld,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ack_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  err,
  input  logic                  sync_rst,
  input  logic [F_WIDTH-1:0]    hw_value,
  input  logic                  hw_pulse,
  output logic [F_WIDTH-1:0]    field_value,
  output logic [ALIAS_NUM-1:0]  swacc
);

  typedef enum logic [1:0] {StIdle, StAccess, StRdPipe, StAck} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   req_addr_q;
  logic                    req_wr_q;
  logic                    req_rd_q;
  logic [F_WIDTH-1:0]      req_wdata_q;
  logic [F_WIDTH-1:0]      field_q;
  logic [F_WIDTH-1:0]      field_d;

`ifdef REGSLV_ALIAS_BANK_RD_PIPE_EN
  logic [DATA_WIDTH-1:0]   pipe_data_q;
  logic                    pipe_err_q;
`endif

  // Only the field slice of wr_data is ever stored.
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data;

  // Alias decode on the latched address.
  logic                 hit;
  logic [ALIAS_NUM-1:0] hit_oh;
  logic                 hit_ro;
  logic                 hit_rclr;

  always_comb begin
    hit      = 1'b0;
    hit_oh   = '0;
    hit_ro   = 1'b0;
    hit_rclr = 1'b0;
    for (int k = 0; k < int'(ALIAS_NUM); k++) begin
      if (req_addr_q == BASE_ADDR + (ADDR_WIDTH'(k) << 2)) begin
        hit       = 1'b1;
        hit_oh[k] = 1'b1;
        hit_ro    = RO_MASK[k];
        hit_rclr  = RCLR_MASK[k];
      end
    end
  end

  logic                  acc_ok;
  logic                  acc_err;
  logic                  sw_we;
  logic                  sw_clr;
  logic [DATA_WIDTH-1:0] rd_val;

  always_comb begin
    acc_ok  = (state_q == StAccess) && hit && (req_wr_q ^ req_rd_q);
    acc_err = !(hit && (req_wr_q ^ req_rd_q));
    sw_we   = acc_ok && req_wr_q && !hit_ro;
    sw_clr  = acc_ok && req_rd_q && hit_rclr;
    rd_val  = '0;
    if (acc_ok && req_rd_q) begin
      rd_val[F_LSB +: F_WIDTH] = field_q;
    end
  end

  // Field priority: sync_rst, then software write/clear, then hardware load.
  always_comb begin
    field_d = field_q;
    if (sync_rst) begin
      field_d = ARST_VALUE;
    end else if (sw_we) begin
      field_d = req_wdata_q;
    end else if (sw_clr) begin
      field_d = '0;
    end else if (hw_pulse) begin
      field_d = hw_value;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      field_q <= ARST_VALUE;
    end else begin
      field_q <= field_d;
    end
  end

  assign field_value = field_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      req_addr_q  <= '0;
      req_wr_q    <= 1'b0;
      req_rd_q    <= 1'b0;
      req_wdata_q <= '0;
      ack_vld     <= 1'b0;
      rd_data     <= '0;
      err         <= 1'b0;
      swacc       <= '0;
`ifdef REGSLV_ALIAS_BANK_RD_PIPE_EN
      pipe_data_q <= '0;
      pipe_err_q  <= 1'b0;
`endif
    end else begin
      ack_vld <= 1'b0;
      swacc   <= '0;
      unique case (state_q)
        StIdle: begin
          if (req_vld) begin
            req_addr_q  <= addr;
            req_wr_q    <= wr_en;
            req_rd_q    <= rd_en;
            req_wdata_q <= wr_data[F_LSB +: F_WIDTH];
            state_q     <= StAccess;
          end
        end
        StAccess: begin
          swacc <= acc_ok ? hit_oh : '0;
`ifdef REGSLV_ALIAS_BANK_RD_PIPE_EN
          pipe_data_q <= rd_val;
          pipe_err_q  <= acc_err;
          state_q     <= StRdPipe;
`else
          rd_data <= rd_val;
          err     <= acc_err;
          ack_vld <= 1'b1;
          state_q <= StAck;
`endif
        end
        StRdPipe: begin
`ifdef REGSLV_ALIAS_BANK_RD_PIPE_EN
          rd_data <= pipe_data_q;
          err     <= pipe_err_q;
          ack_vld <= 1'b1;
`endif
          state_q <= StAck;
        end
        StAck: begin
          rd_data <= '0;
          err     <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regslv_alias_bank.sv
// Directed bench for regslv_alias_bank. It uses a table of single-transaction vectors and
// a few hand-written sequences for hardware load, sync reset, ignored requests, and
// reset in the middle of a transaction.
module tb_regslv_alias_bank;

  localparam logic [63:0] BASE = 64'h100;
`ifdef REGSLV_ALIAS_BANK_RD_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_vld = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [63:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic        ack_vld;
  logic [31:0] rd_data;
  logic        err;
  logic        sync_rst = 1'b0;
  logic [7:0]  hw_value = '0;
  logic        hw_pulse = 1'b0;
  logic [7:0]  field_value;
  logic [3:0]  swacc;

  always #5 clk = ~clk;

  regslv_alias_bank #(
    .ADDR_WIDTH (64),
    .DATA_WIDTH (32),
    .F_WIDTH    (8),
    .F_LSB      (0),
    .ALIAS_NUM  (4),
    .BASE_ADDR  (BASE),
    .RO_MASK    (4'b0010),
    .RCLR_MASK  (4'b0100),
    .ARST_VALUE (8'h5A)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_vld     (req_vld),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .addr        (addr),
    .wr_data     (wr_data),
    .ack_vld     (ack_vld),
    .rd_data     (rd_data),
    .err         (err),
    .sync_rst    (sync_rst),
    .hw_value    (hw_value),
    .hw_pulse    (hw_pulse),
    .field_value (field_value),
    .swacc       (swacc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One transaction. Optional hw_pulse/sync_rst are driven in the ACCESS cycle.
  // swacc is ORed over every cycle up to and including the ack.
  task automatic txn(input logic w, input logic r, input logic [63:0] a, input logic [31:0] d,
                     input logic hp, input logic [7:0] hv, input logic sr,
                     output logic [31:0] rdat, output logic e, output int lat,
                     output logic [3:0] sw);
    @(negedge clk);
    req_vld = 1'b1; wr_en = w; rd_en = r; addr = a; wr_data = d;
    @(negedge clk);
    req_vld = 1'b0;
    hw_pulse = hp; hw_value = hv; sync_rst = sr;
    lat = 1;
    sw = '0;
    while (!ack_vld && lat < 10) begin
      sw |= swacc;
      @(negedge clk);
      hw_pulse = 1'b0; sync_rst = 1'b0;
      lat++;
    end
    sw |= swacc;
    rdat = rd_data;
    e = err;
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [63:0] a;
    logic [31:0] d;
    logic [31:0] erd;
    logic        eerr;
    logic [7:0]  efield;
    logic [3:0]  esw;
  } vec_t;

  vec_t vecs[12];

  logic [31:0] rdat;
  logic        e;
  int          lat;
  logic [3:0]  sw;
  int          acks;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, BASE + 64'd0,  32'h0000_00C3, 32'h0,  1'b0, 8'hC3, 4'b0001};
    vecs[1]  = '{1'b0, 1'b1, BASE + 64'd4,  32'h0,         32'hC3, 1'b0, 8'hC3, 4'b0010};
    vecs[2]  = '{1'b1, 1'b0, BASE + 64'd4,  32'h0000_0011, 32'h0,  1'b0, 8'hC3, 4'b0010};
    vecs[3]  = '{1'b1, 1'b0, BASE + 64'd12, 32'h0000_007E, 32'h0,  1'b0, 8'h7E, 4'b1000};
    vecs[4]  = '{1'b0, 1'b1, BASE + 64'd8,  32'h0,         32'h7E, 1'b0, 8'h00, 4'b0100};
    vecs[5]  = '{1'b0, 1'b1, BASE + 64'd0,  32'h0,         32'h00, 1'b0, 8'h00, 4'b0001};
    vecs[6]  = '{1'b0, 1'b1, BASE + 64'd16, 32'h0,         32'h0,  1'b1, 8'h00, 4'b0000};
    vecs[7]  = '{1'b1, 1'b1, BASE + 64'd0,  32'h0000_00FF, 32'h0,  1'b1, 8'h00, 4'b0000};
    vecs[8]  = '{1'b0, 1'b0, BASE + 64'd0,  32'h0000_00FF, 32'h0,  1'b1, 8'h00, 4'b0000};
    vecs[9]  = '{1'b1, 1'b0, BASE + 64'd0,  32'hFFFF_FF3C, 32'h0,  1'b0, 8'h3C, 4'b0001};
    vecs[10] = '{1'b0, 1'b1, BASE + 64'd12, 32'h0,         32'h3C, 1'b0, 8'h3C, 4'b1000};
    vecs[11] = '{1'b0, 1'b1, BASE + 64'd2,  32'h0,         32'h0,  1'b1, 8'h3C, 4'b0000};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_field", field_value, 8'h5A);
    check("rst_ack", ack_vld, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rdata", rd_data, 32'h0);
    check("rst_swacc", swacc, 4'h0);
    rstn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, 1'b0, 8'h0, 1'b0, rdat, e, lat, sw);
      check($sformatf("v%0d_lat", i), lat, LAT);
      check($sformatf("v%0d_rdata", i), rdat, vecs[i].erd);
      check($sformatf("v%0d_err", i), e, vecs[i].eerr);
      check($sformatf("v%0d_field", i), field_value, vecs[i].efield);
      check($sformatf("v%0d_swacc", i), sw, vecs[i].esw);
      @(negedge clk);
      check($sformatf("v%0d_ack_drop", i), ack_vld, 1'b0);
    end

    // Hardware load while idle.
    @(negedge clk);
    hw_value = 8'h99; hw_pulse = 1'b1;
    @(negedge clk);
    hw_pulse = 1'b0;
    check("hw_load", field_value, 8'h99);

    // A software write wins over a simultaneous hardware load.
    txn(1'b1, 1'b0, BASE, 32'hAA, 1'b1, 8'h55, 1'b0, rdat, e, lat, sw);
    check("sw_over_hw_lat", lat, LAT);
    check("sw_over_hw_field", field_value, 8'hAA);

    // sync_rst overrides both; the transaction still completes.
    txn(1'b1, 1'b0, BASE, 32'hAA, 1'b1, 8'h55, 1'b1, rdat, e, lat, sw);
    check("srst_lat", lat, LAT);
    check("srst_err", e, 1'b0);
    check("srst_field", field_value, 8'h5A);

    // req_vld held high through ACCESS/ACK is ignored: one ack, and the field is untouched.
    @(negedge clk);
    req_vld = 1'b1; wr_en = 1'b0; rd_en = 1'b1; addr = BASE + 64'd4;
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b0; addr = BASE; wr_data = 32'h12;
    acks = 0;
    for (int c = 1; c <= 10; c++) begin
      if (ack_vld) begin
        acks++;
        check("ign_rdata", rd_data, 32'h5A);
      end
      if (c == LAT) req_vld = 1'b0;
      @(negedge clk);
    end
    check("ign_acks", acks, 1);
    check("ign_field", field_value, 8'h5A);

    // Reset asserted during ACCESS aborts the transaction.
    txn(1'b1, 1'b0, BASE, 32'h0, 1'b0, 8'h0, 1'b0, rdat, e, lat, sw);
    check("pre_abort_field", field_value, 8'h00);
    @(negedge clk);
    req_vld = 1'b1; wr_en = 1'b1; rd_en = 1'b0; addr = BASE; wr_data = 32'h77;
    @(negedge clk);
    req_vld = 1'b0;
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ack_vld) acks++;
    end
    check("abort_acks", acks, 0);
    check("abort_field", field_value, 8'h5A);

    // After the abort, the bank works normally.
    txn(1'b0, 1'b1, BASE + 64'd12, 32'h0, 1'b0, 8'h0, 1'b0, rdat, e, lat, sw);
    check("post_abort_lat", lat, LAT);
    check("post_abort_rdata", rdat, 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
